muldiv_ctrl: RTL and testbench

//  Shared iterative MUL/DIV unit and sequencer for all harts. Accepts one M-extension op from EX,

---
 rtl/muldiv_ctrl_pkg.sv | 39 +++
 rtl/muldiv_iter_core.sv | 71 +++++++
 rtl/muldiv_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the M-extension multiply/divide sequencer.
// Op codes follow the RISC-V funct3 encoding so EX can pass funct3 straight through.
package muldiv_ctrl_pkg;

   localparam int XLEN       = 32;
   localparam int HART_ID_W  = 2;
   localparam int REG_ADDR_W = 5;
   localparam int MD_OP_W    = 3;
   localparam int MD_ST_W    = 2;
   localparam int CNT_W      = $clog2(XLEN);

   typedef enum logic [MD_OP_W-1:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [MD_ST_W-1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   function automatic logic op_a_signed(input logic [MD_OP_W-1:0] op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   // MULHSU deliberately treats rs2 as unsigned.
   function automatic logic op_b_signed(input logic [MD_OP_W-1:0] op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 shift/add (multiply) and restoring shift/subtract (divide) datapath on magnitudes.
// The start edge already performs the first iteration; each step performs one more.
module muldiv_iter_core
   import muldiv_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                step,
   input  logic                is_div,
   input  logic [XLEN-1:0]     a_mag,
   input  logic [XLEN-1:0]     b_mag,
   output logic [2*XLEN-1:0]   product,
   output logic [XLEN-1:0]     quotient,
   output logic [XLEN-1:0]     remainder
);

   // hi holds the partial product / partial remainder, lo the multiplier / quotient bits.
   logic [XLEN:0]   hi_reg, hi_cur, hi_next;
   logic [XLEN-1:0] lo_reg, lo_cur, lo_next;
   logic [XLEN-1:0] b_reg, b_cur;
   logic            div_reg, div_cur;

   logic [XLEN:0]   shifted;
   logic [XLEN+1:0] diff;
   logic [XLEN:0]   sum;

   assign hi_cur  = start ? '0     : hi_reg;
   assign lo_cur  = start ? a_mag  : lo_reg;
   assign b_cur   = start ? b_mag  : b_reg;
   assign div_cur = start ? is_div : div_reg;

   assign shifted = {hi_cur[XLEN-1:0], lo_cur[XLEN-1]};
   assign diff    = {1'b0, shifted} - {2'b00, b_cur};
   assign sum     = hi_cur + (lo_cur[0] ? {1'b0, b_cur} : '0);

   always_comb begin
      hi_next = hi_cur;
      lo_next = lo_cur;
      if (div_cur) begin
         if (!diff[XLEN+1]) begin
            hi_next = diff[XLEN:0];
            lo_next = {lo_cur[XLEN-2:0], 1'b1};
         end else begin
            hi_next = shifted;
            lo_next = {lo_cur[XLEN-2:0], 1'b0};
         end
      end else begin
         {hi_next, lo_next} = {1'b0, sum, lo_cur[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_reg  <= '0;
         lo_reg  <= '0;
         b_reg   <= '0;
         div_reg <= 1'b0;
      end else if (start || step) begin
         hi_reg  <= hi_next;
         lo_reg  <= lo_next;
         b_reg   <= b_cur;
         div_reg <= div_cur;
      end
   end

   assign product   = {hi_reg[XLEN-1:0], lo_reg};
   assign quotient  = lo_reg;
   assign remainder = hi_reg[XLEN-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// Shared MUL/DIV sequencer: accepts one op from any hart, iterates, then holds the result
// until the writeback arbiter fires. Tracks ownership for per-hart busy and kill.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int N_HARTS  = 4,
   parameter int FAST_MUL = 0
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [HART_ID_W-1:0]  req_hart_id,
   input  logic [REG_ADDR_W-1:0] req_rd,
   input  logic [MD_OP_W-1:0]    req_op,
   input  logic [XLEN-1:0]       req_a,
   input  logic [XLEN-1:0]       req_b,
   input  logic                  kill_valid,
   input  logic [HART_ID_W-1:0]  kill_hart_id,
   output logic                  muldiv_pending,
   output logic [HART_ID_W-1:0]  muldiv_pending_hart_id,
   output logic [REG_ADDR_W-1:0] muldiv_pending_rd,
   output logic [XLEN-1:0]       muldiv_pending_result,
   input  logic                  muldiv_wb_fire,
   output logic [N_HARTS-1:0]    hart_busy
);

   md_state_e             state_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic [HART_ID_W-1:0]  owner_reg;
   logic [REG_ADDR_W-1:0] rd_reg;
   md_op_e                op_reg;
   logic                  neg_reg;
   logic                  busy_reg;
   logic                  req_ready_reg;
   logic                  pending_reg;
   logic [HART_ID_W-1:0]  pend_hart_reg;
   logic [REG_ADDR_W-1:0] pend_rd_reg;
   logic [XLEN-1:0]       pend_result_reg;

   md_op_e          req_op_e;
   logic            req_is_div;
   logic            a_neg, b_neg, req_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, use_fast;
   logic [XLEN-1:0] fast_mul_result, special_result;
   logic            kill_own;
   logic            core_start, core_step;

   logic [2*XLEN-1:0] core_product, prod_fix;
   logic [XLEN-1:0]   core_quotient, core_remainder, quo_fix, rem_fix, fix_result;

   assign req_op_e   = md_op_e'(req_op);
   assign req_is_div = req_op[2];
   assign a_neg      = op_a_signed(req_op) & req_a[XLEN-1];
   assign b_neg      = op_b_signed(req_op) & req_b[XLEN-1];
   assign a_mag      = a_neg ? -req_a : req_a;
   assign b_mag      = b_neg ? -req_b : req_b;
   // Remainders take the dividend's sign; quotients and products take the xor of both.
   assign req_neg    = (req_op[2] & req_op[1]) ? a_neg : (a_neg ^ b_neg);

   assign div_zero = req_is_div && (req_b == '0);
   assign div_ovf  = ((req_op_e == MD_DIV) || (req_op_e == MD_REM)) &&
                     (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);

   generate
      if (FAST_MUL != 0) begin : g_fast_mul
         logic [2*XLEN-1:0] a_ext, b_ext, prod;
         assign a_ext = {{XLEN{a_neg}}, req_a};
         assign b_ext = {{XLEN{b_neg}}, req_b};
         assign prod  = a_ext * b_ext;
         assign fast_mul_result = (req_op_e == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else begin : g_iter_mul
         assign fast_mul_result = '0;
      end
   endgenerate

   assign use_fast = (!req_is_div && (FAST_MUL != 0)) || div_zero || div_ovf;

   always_comb begin
      special_result = fast_mul_result;
      if (div_zero) begin
         special_result = req_op[1] ? req_a : '1;
      end else if (div_ovf) begin
         special_result = req_op[1] ? '0 : req_a;
      end
   end

   assign kill_own   = kill_valid && (kill_hart_id == owner_reg);
   assign core_start = (state_reg == ST_IDLE) && req_valid && !use_fast;
   assign core_step  = (state_reg == ST_CALC);

   muldiv_iter_core u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (core_start),
      .step      (core_step),
      .is_div    (req_is_div),
      .a_mag     (a_mag),
      .b_mag     (b_mag),
      .product   (core_product),
      .quotient  (core_quotient),
      .remainder (core_remainder)
   );

   assign prod_fix = neg_reg ? -core_product   : core_product;
   assign quo_fix  = neg_reg ? -core_quotient  : core_quotient;
   assign rem_fix  = neg_reg ? -core_remainder : core_remainder;

   always_comb begin
      case (op_reg)
         MD_MUL:                    fix_result = prod_fix[XLEN-1:0];
         MD_MULH, MD_MULHSU,
         MD_MULHU:                  fix_result = prod_fix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:           fix_result = quo_fix;
         default:                   fix_result = rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         owner_reg       <= '0;
         rd_reg          <= '0;
         op_reg          <= MD_MUL;
         neg_reg         <= 1'b0;
         busy_reg        <= 1'b0;
         req_ready_reg   <= 1'b1;
         pending_reg     <= 1'b0;
         pend_hart_reg   <= '0;
         pend_rd_reg     <= '0;
         pend_result_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  owner_reg     <= req_hart_id;
                  rd_reg        <= req_rd;
                  op_reg        <= req_op_e;
                  neg_reg       <= req_neg;
                  busy_reg      <= 1'b1;
                  req_ready_reg <= 1'b0;
                  if (use_fast) begin
                     state_reg       <= ST_DONE;
                     pending_reg     <= 1'b1;
                     pend_hart_reg   <= req_hart_id;
                     pend_rd_reg     <= req_rd;
                     pend_result_reg <= special_result;
                  end else begin
                     state_reg <= ST_CALC;
                     cnt_reg   <= CNT_W'(XLEN-1);
                  end
               end
            end
            // The accept edge did iteration 0, so CALC covers the remaining XLEN-1.
            ST_CALC: begin
               if (kill_own) begin
                  state_reg     <= ST_IDLE;
                  busy_reg      <= 1'b0;
                  req_ready_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
                  if (cnt_reg == CNT_W'(1)) begin
                     state_reg <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               if (kill_own) begin
                  state_reg     <= ST_IDLE;
                  busy_reg      <= 1'b0;
                  req_ready_reg <= 1'b1;
               end else begin
                  state_reg       <= ST_DONE;
                  pending_reg     <= 1'b1;
                  pend_hart_reg   <= owner_reg;
                  pend_rd_reg     <= rd_reg;
                  pend_result_reg <= fix_result;
               end
            end
            // A fire in the same cycle as a kill has already written back; both end here.
            ST_DONE: begin
               if (muldiv_wb_fire || kill_own) begin
                  state_reg     <= ST_IDLE;
                  pending_reg   <= 1'b0;
                  busy_reg      <= 1'b0;
                  req_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               pending_reg   <= 1'b0;
               busy_reg      <= 1'b0;
               req_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < N_HARTS; gi++) begin : g_busy
         assign hart_busy[gi] = busy_reg && (owner_reg == HART_ID_W'(gi));
      end
   endgenerate

   assign req_ready              = req_ready_reg;
   assign muldiv_pending         = pending_reg;
   assign muldiv_pending_hart_id = pend_hart_reg;
   assign muldiv_pending_rd      = pend_rd_reg;
   assign muldiv_pending_result  = pend_result_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: unit 0 is built with iterative multiply, unit 1 with the
// single-cycle multiplier. Drivers push expected writebacks; per-unit monitors pop and compare.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic                  req_valid    [2];
   logic                  req_ready    [2];
   logic [HART_ID_W-1:0]  req_hart_id  [2];
   logic [REG_ADDR_W-1:0] req_rd       [2];
   logic [MD_OP_W-1:0]    req_op       [2];
   logic [XLEN-1:0]       req_a        [2];
   logic [XLEN-1:0]       req_b        [2];
   logic                  kill_valid   [2];
   logic [HART_ID_W-1:0]  kill_hart_id [2];
   logic                  pending      [2];
   logic [HART_ID_W-1:0]  pend_hart    [2];
   logic [REG_ADDR_W-1:0] pend_rd      [2];
   logic [XLEN-1:0]       pend_result  [2];
   logic [3:0]            hart_busy    [2];

   typedef struct {
      int          unit;
      logic [1:0]  hart;
      logic [4:0]  rd;
      logic [31:0] res;
      int          lat;
      int          hold;
      int          c0;
   } exp_t;

   exp_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unit
         logic fire;
         exp_t cur;
         int   hold_cnt;
         bit   active;
         bit   stray;
         bit   post_fire;

         muldiv_ctrl #(.N_HARTS(4), .FAST_MUL(gi)) dut (
            .clk                    (clk),
            .rst                    (rst),
            .req_valid              (req_valid[gi]),
            .req_ready              (req_ready[gi]),
            .req_hart_id            (req_hart_id[gi]),
            .req_rd                 (req_rd[gi]),
            .req_op                 (req_op[gi]),
            .req_a                  (req_a[gi]),
            .req_b                  (req_b[gi]),
            .kill_valid             (kill_valid[gi]),
            .kill_hart_id           (kill_hart_id[gi]),
            .muldiv_pending         (pending[gi]),
            .muldiv_pending_hart_id (pend_hart[gi]),
            .muldiv_pending_rd      (pend_rd[gi]),
            .muldiv_pending_result  (pend_result[gi]),
            .muldiv_wb_fire         (fire),
            .hart_busy              (hart_busy[gi])
         );

         always @(negedge clk) begin
            if (rst) begin
               fire      = 1'b0;
               active    = 1'b0;
               stray     = 1'b0;
               post_fire = 1'b0;
               hold_cnt  = 0;
            end else begin
               fire = 1'b0;
               if (post_fire) begin
                  post_fire = 1'b0;
                  chk("pending_cleared", 32'(pending[gi]), 32'd0);
                  chk("busy_cleared", 32'(hart_busy[gi]), 32'd0);
                  chk("ready_after_fire", 32'(req_ready[gi]), 32'd1);
               end else if (pending[gi]) begin
                  if (!active) begin
                     active   = 1'b1;
                     hold_cnt = 0;
                     stray    = (sb_q.size() == 0);
                     if (stray) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pending unit=%0d: result %h, none expected",
                                 gi, pend_result[gi]);
                        cur.hold = 0;
                     end else begin
                        cur = sb_q.pop_front();
                        chk("unit", 32'(gi), 32'(cur.unit));
                        chk("latency", 32'(cyc - cur.c0), 32'(cur.lat));
                        $display("txn unit=%0d hart=%0d rd=%0d result=%h latency=%0d",
                                 gi, pend_hart[gi], pend_rd[gi], pend_result[gi], cyc - cur.c0);
                     end
                  end
                  if (!stray) begin
                     chk("result", pend_result[gi], cur.res);
                     chk("pend_hart", 32'(pend_hart[gi]), 32'(cur.hart));
                     chk("pend_rd", 32'(pend_rd[gi]), 32'(cur.rd));
                     chk("busy_while_pending", 32'(hart_busy[gi]), 32'd1 << cur.hart);
                     chk("ready_while_pending", 32'(req_ready[gi]), 32'd0);
                  end
                  if (hold_cnt >= cur.hold) begin
                     fire      = 1'b1;
                     active    = 1'b0;
                     post_fire = 1'b1;
                  end else begin
                     hold_cnt++;
                  end
               end
            end
         end
      end
   endgenerate

   task automatic issue(input int u, input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] hart, input logic [4:0] rd, input logic [31:0] res,
                        input int lat, input int hold, input bit push);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      while (!req_ready[u] && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready[u]) begin
         total++;
         bad++;
         $display("FAIL issue_timeout unit=%0d: req_ready=0 expected 1", u);
         return;
      end
      req_valid[u]   = 1'b1;
      req_op[u]      = op;
      req_a[u]       = a;
      req_b[u]       = b;
      req_hart_id[u] = hart;
      req_rd[u]      = rd;
      if (push) begin
         e.unit = u;
         e.hart = hart;
         e.rd   = rd;
         e.res  = res;
         e.lat  = lat;
         e.hold = hold;
         e.c0   = cyc;
         sb_q.push_back(e);
      end
      @(negedge clk);
      req_valid[u] = 1'b0;
      chk("busy_after_accept", 32'(hart_busy[u]), 32'd1 << hart);
      chk("ready_after_accept", 32'(req_ready[u]), 32'd0);
   endtask

   task automatic drain(input int u);
      int guard;
      guard = 0;
      while ((sb_q.size() != 0 || !req_ready[u]) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) begin
         total++;
         bad++;
         $display("FAIL drain_timeout unit=%0d: queue=%0d ready=%0d", u, sb_q.size(), req_ready[u]);
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input int u);
      chk("rst_ready", 32'(req_ready[u]), 32'd1);
      chk("rst_pending", 32'(pending[u]), 32'd0);
      chk("rst_busy", 32'(hart_busy[u]), 32'd0);
      chk("rst_hart", 32'(pend_hart[u]), 32'd0);
      chk("rst_rd", 32'(pend_rd[u]), 32'd0);
      chk("rst_result", pend_result[u], 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         req_valid[u]    = 1'b0;
         req_hart_id[u]  = '0;
         req_rd[u]       = '0;
         req_op[u]       = '0;
         req_a[u]        = '0;
         req_b[u]        = '0;
         kill_valid[u]   = 1'b0;
         kill_hart_id[u] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_state(0);
      chk_reset_state(1);

      // Iterative unit: divide cases, stable hold, back-to-back accept.
      issue(0, MD_DIV,  32'hFFFF_FFF9, 32'd2, 2'd1, 5'd5, 32'hFFFF_FFFD, 33, 3, 1);
      drain(0);
      issue(0, MD_DIVU, 32'd100, 32'd7, 2'd0, 5'd7, 32'd14, 33, 5, 1);
      issue(0, MD_REMU, 32'd100, 32'd7, 2'd3, 5'd8, 32'd2,  33, 0, 1);
      issue(0, MD_REM,  32'hFFFF_FFF9, 32'd2, 2'd0, 5'd6, 32'hFFFF_FFFF, 33, 0, 1);
      issue(0, MD_DIVU, 32'd7, 32'd0, 2'd2, 5'd1, 32'hFFFF_FFFF, 1, 0, 1);
      issue(0, MD_REMU, 32'd7, 32'd0, 2'd2, 5'd2, 32'd7,         1, 0, 1);
      issue(0, MD_DIV,  32'd7, 32'd0, 2'd1, 5'd3, 32'hFFFF_FFFF, 1, 0, 1);
      issue(0, MD_REM,  32'd7, 32'd0, 2'd1, 5'd4, 32'd7,         1, 0, 1);
      issue(0, MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 5'd9,  32'h8000_0000, 1, 0, 1);
      issue(0, MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 5'd10, 32'd0,         1, 0, 1);
      issue(0, MD_DIV,  32'd7, 32'hFFFF_FFFE, 2'd0, 5'd11, 32'hFFFF_FFFD, 33, 0, 1);
      issue(0, MD_REM,  32'd7, 32'hFFFF_FFFE, 2'd0, 5'd12, 32'd1,         33, 0, 1);
      issue(0, MD_MULH,   32'h8000_0000, 32'h8000_0000, 2'd1, 5'd13, 32'h4000_0000, 33, 0, 1);
      issue(0, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 5'd14, 32'hFFFF_FFFF, 33, 0, 1);
      issue(0, MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 5'd15, 32'hFFFF_FFFE, 33, 0, 1);
      issue(0, MD_MUL,    32'd3, 32'hFFFF_FFFB, 2'd3, 5'd0, 32'hFFFF_FFF1, 33, 0, 1);
      drain(0);

      // Owner kill mid-CALC: unit returns to idle with nothing to write back.
      issue(0, MD_DIV, 32'hFFFF_FFF9, 32'd2, 2'd2, 5'd9, 32'd0, 0, 0, 0);
      repeat (9) @(negedge clk);
      chk("busy_in_calc", 32'(hart_busy[0]), 32'h4);
      kill_valid[0]   = 1'b1;
      kill_hart_id[0] = 2'd2;
      @(negedge clk);
      kill_valid[0] = 1'b0;
      chk("kill_pending", 32'(pending[0]), 32'd0);
      chk("kill_busy", 32'(hart_busy[0]), 32'd0);
      chk("kill_ready", 32'(req_ready[0]), 32'd1);
      repeat (40) @(negedge clk);

      // Kill for a hart that does not own the op is ignored.
      issue(0, MD_DIVU, 32'd100, 32'd7, 2'd2, 5'd10, 32'd14, 33, 0, 1);
      repeat (4) @(negedge clk);
      kill_valid[0]   = 1'b1;
      kill_hart_id[0] = 2'd0;
      @(negedge clk);
      kill_valid[0] = 1'b0;
      drain(0);

      // Kill together with fire in the first DONE cycle: the write still happens.
      issue(0, MD_DIV, 32'd7, 32'd0, 2'd2, 5'd11, 32'hFFFF_FFFF, 1, 0, 1);
      kill_valid[0]   = 1'b1;
      kill_hart_id[0] = 2'd2;
      @(negedge clk);
      kill_valid[0] = 1'b0;
      drain(0);

      // Kill and request for the same hart while idle: accept proceeds.
      kill_valid[0]   = 1'b1;
      kill_hart_id[0] = 2'd1;
      issue(0, MD_REMU, 32'd100, 32'd7, 2'd1, 5'd12, 32'd2, 33, 0, 1);
      kill_valid[0] = 1'b0;
      drain(0);

      // Reset in the middle of an op drops it and restores reset values.
      issue(0, MD_DIV, 32'hFFFF_FFF9, 32'd2, 2'd3, 5'd13, 32'd0, 0, 0, 0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_state(0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      // Single-cycle multiplier unit.
      issue(1, MD_MULH,   32'h8000_0000, 32'h8000_0000, 2'd1, 5'd13, 32'h4000_0000, 1, 0, 1);
      issue(1, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 5'd14, 32'hFFFF_FFFF, 1, 0, 1);
      issue(1, MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 5'd15, 32'hFFFF_FFFE, 1, 2, 1);
      issue(1, MD_MUL,    32'd3, 32'hFFFF_FFFB, 2'd0, 5'd0, 32'hFFFF_FFF1, 1, 0, 1);
      issue(1, MD_DIV,    32'hFFFF_FFF9, 32'd2, 2'd1, 5'd5, 32'hFFFF_FFFD, 33, 0, 1);
      drain(1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
